// File: rtl/intdiv_seq_pkg.sv
// Shared integer-unit types for the bexkat1 execute stage.
// Function codes, divider state encoding and func helpers.
package bexkat1Def;

  typedef enum logic [3:0] {
    INT_ADD, INT_SUB, INT_AND, INT_OR,
    INT_XOR, INT_LSL, INT_LSR, INT_ASR,
    INT_MUL, INT_MULU, INT_DIV, INT_DIVU,
    INT_MOD, INT_MODU, INT_NEG, INT_COM
  } intfunc_t;

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } divstate_t;

  function automatic logic is_divfunc(
    input intfunc_t f
  );
    return (f == INT_DIV) || (f == INT_MOD) ||
           (f == INT_DIVU) || (f == INT_MODU);
  endfunction

  function automatic logic is_signed_div(
    input intfunc_t f
  );
    return (f == INT_DIV) || (f == INT_MOD);
  endfunction

  function automatic logic is_modfunc(
    input intfunc_t f
  );
    return (f == INT_MOD) || (f == INT_MODU);
  endfunction

endpackage

// File: rtl/intdiv_seq_if.sv
// Request/response bundle between the execute stage
// and the sequential divider.
interface intdiv_seq_if #(
  parameter int WIDTH = 32
);
  import bexkat1Def::*;

  logic             in_valid;
  logic             in_ready;
  intfunc_t         func;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             dbz;

  modport master (
    output in_valid, func, dividend, divisor,
    output out_ready,
    input  in_ready, out_valid, out, dbz
  );

  modport slave (
    input  in_valid, func, dividend, divisor,
    input  out_ready,
    output in_ready, out_valid, out, dbz
  );

endinterface

// File: rtl/intdiv_seq_step.sv
// One restoring-division iteration: shift {rem,quo}
// left and subtract the divisor if it fits.
module intdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_n,
  output logic [WIDTH-1:0] quo_n
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] trial;

  always_comb begin
    sh    = {rem, quo[WIDTH-1]};
    trial = sh - {2'b00, divisor};
    if (!trial[WIDTH+1]) begin
      rem_n = trial[WIDTH:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = sh[WIDTH:0];
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/intdiv_seq.sv
// Multi-cycle radix-2 restoring divider for the bexkat1
// execute stage; one quotient bit per cycle.
module intdiv_seq
  import bexkat1Def::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        kill_i,
  intdiv_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  divstate_t        state, state_n;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem, rem_n;
  logic [WIDTH-1:0] quo, quo_n, dvs;
  intfunc_t         func_q;
  logic             neg_q, neg_r;
  logic [WIDTH-1:0] out_q;
  logic             dbz_q;

  logic             accept, is_zero, valid_f;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign accept  = bus.in_valid & bus.in_ready;
  assign is_zero = (bus.divisor == '0);
  assign valid_f = is_divfunc(bus.func);
  assign a_neg   = is_signed_div(bus.func) & bus.dividend[WIDTH-1];
  assign b_neg   = is_signed_div(bus.func) & bus.divisor[WIDTH-1];
  assign a_abs   = a_neg ? -bus.dividend : bus.dividend;
  assign b_abs   = b_neg ? -bus.divisor : bus.divisor;
  assign q_fix   = neg_q ? -quo : quo;
  assign r_fix   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  intdiv_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dvs),
    .rem_n   (rem_n),
    .quo_n   (quo_n)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (accept)
          state_n = (!valid_f || is_zero) ? DONE : CALC;
      CALC:
        if (count == CW'(1)) state_n = FIX;
      FIX:
        state_n = DONE;
      DONE:
        if (bus.out_ready) state_n = IDLE;
      default:
        state_n = IDLE;
    endcase
    // Flush beats both accept and consume.
    if (kill_i) state_n = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count  <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      func_q <= INT_ADD;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      out_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      if (accept && !kill_i) begin
        func_q <= bus.func;
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        rem    <= '0;
        quo    <= a_abs;
        dvs    <= b_abs;
        count  <= CW'(WIDTH);
        if (!valid_f) begin
          out_q <= '0;
          dbz_q <= 1'b0;
        end else if (is_zero) begin
          out_q <= is_modfunc(bus.func) ? bus.dividend : '1;
          dbz_q <= 1'b1;
        end
      end
      if (state == CALC) begin
        rem   <= rem_n;
        quo   <= quo_n;
        count <= count - 1'b1;
      end
      if (state == FIX) begin
        out_q <= is_modfunc(func_q) ? r_fix : q_fix;
        dbz_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out       = out_q;
  assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_intdiv_seq.sv
// Directed-vector bench for intdiv_seq.
// Inputs change on negedge, outputs sampled on negedge.
module tb_intdiv_seq;
  import bexkat1Def::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic kill_i = 1'b0;
  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  intdiv_seq_if #(.WIDTH(W)) bus ();

  intdiv_seq #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .kill_i (kill_i),
    .bus    (bus)
  );

  task automatic start_op(input intfunc_t f,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b);
    bus.func     = f;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.func     = INT_ADD;
    bus.dividend = 32'hDEADBEEF;
    bus.divisor  = 32'h0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out !== 32'h0 || bus.dbz !== 1'b0) begin
      errs++;
      $display("FAIL reset: rdy=%b vld=%b out=%h dbz=%b want 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.out, bus.dbz);
    end
    rst_i = 1'b1;
  endtask

  task automatic test_divide();
    intfunc_t    fs[7];
    logic [31:0] as[7];
    logic [31:0] bs[7];
    logic [31:0] ex[7];
    int lat;
    fs[0] = INT_DIVU; as[0] = 100;          bs[0] = 7;
    ex[0] = 14;
    fs[1] = INT_MODU; as[1] = 100;          bs[1] = 7;
    ex[1] = 2;
    fs[2] = INT_DIV;  as[2] = 32'hFFFFFFF9; bs[2] = 2;
    ex[2] = 32'hFFFFFFFD;
    fs[3] = INT_MOD;  as[3] = 32'hFFFFFFF9; bs[3] = 2;
    ex[3] = 32'hFFFFFFFF;
    fs[4] = INT_MOD;  as[4] = 7;            bs[4] = 32'hFFFFFFFE;
    ex[4] = 1;
    fs[5] = INT_DIV;  as[5] = 32'h80000000; bs[5] = 32'hFFFFFFFF;
    ex[5] = 32'h80000000;
    fs[6] = INT_MOD;  as[6] = 32'h80000000; bs[6] = 32'hFFFFFFFF;
    ex[6] = 0;
    for (int i = 0; i < 7; i++) begin
      start_op(fs[i], as[i], bs[i]);
      wait_done(lat);
      vecs++;
      if (lat !== 34) begin
        errs++;
        $display("FAIL div%0d_latency: got %0d want 34", i, lat);
      end
      vecs++;
      if (bus.out !== ex[i] || bus.dbz !== 1'b0) begin
        errs++;
        $display("FAIL div%0d_result: out=%h dbz=%b want %h 0",
                 i, bus.out, bus.dbz, ex[i]);
      end
      consume();
    end
  endtask

  task automatic test_div_zero();
    intfunc_t    fs[3];
    logic [31:0] as[3];
    logic [31:0] ex[3];
    logic        ez[3];
    int lat;
    fs[0] = INT_DIVU; as[0] = 32'h1234;     ex[0] = 32'hFFFFFFFF;
    ez[0] = 1'b1;
    fs[1] = INT_MOD;  as[1] = 32'hFFFFFFFB; ex[1] = 32'hFFFFFFFB;
    ez[1] = 1'b1;
    fs[2] = INT_ADD;  as[2] = 32'h55;       ex[2] = 32'h0;
    ez[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_op(fs[i], as[i], 32'h0);
      wait_done(lat);
      vecs++;
      if (lat !== 1) begin
        errs++;
        $display("FAIL short%0d_latency: got %0d want 1", i, lat);
      end
      vecs++;
      if (bus.out !== ex[i] || bus.dbz !== ez[i]) begin
        errs++;
        $display("FAIL short%0d_result: out=%h dbz=%b want %h %b",
                 i, bus.out, bus.dbz, ex[i], ez[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(INT_DIVU, 1000, 10);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      vecs++;
      if (bus.out !== 32'd100 || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b1) begin
        errs++;
        $display("FAIL hold%0d: out=%h rdy=%b vld=%b want 64 0 1",
                 i, bus.out, bus.in_ready, bus.out_valid);
      end
      @(posedge clk);
      @(negedge clk);
    end
    consume();
    vecs++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out !== 32'd100) begin
      errs++;
      $display("FAIL release: rdy=%b vld=%b out=%h want 1 0 64",
               bus.in_ready, bus.out_valid, bus.out);
    end
  endtask

  task automatic test_reset_mid();
    start_op(INT_DIVU, 32'hFFFF0000, 3);
    repeat (16) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    vecs++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.out !== 32'h0) begin
      errs++;
      $display("FAIL reset_mid: rdy=%b vld=%b out=%h want 1 0 0",
               bus.in_ready, bus.out_valid, bus.out);
    end
  endtask

  task automatic test_kill();
    int lat;
    start_op(INT_DIVU, 1000, 7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    kill_i       = 1'b1;
    bus.in_valid = 1'b1;
    bus.func     = INT_DIVU;
    bus.dividend = 50;
    bus.divisor  = 5;
    @(posedge clk);
    @(negedge clk);
    kill_i       = 1'b0;
    bus.in_valid = 1'b0;
    vecs++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL kill_idle: rdy=%b vld=%b want 1 0",
               bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    vecs++;
    if (bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL kill_noaccept: rdy=%b want 1", bus.in_ready);
    end
    start_op(INT_DIVU, 9, 3);
    wait_done(lat);
    vecs++;
    if (lat !== 34 || bus.out !== 32'd3) begin
      errs++;
      $display("FAIL after_kill: lat=%0d out=%h want 34 3",
               lat, bus.out);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [31:0] ex[2];
    int n;
    ex[0] = 9;
    ex[1] = 1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) start_op(INT_DIVU, 81, 9);
      else        start_op(INT_MODU, 81, 10);
      n = 1;
      while (bus.in_ready !== 1'b1 && n < 200) begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end
      vecs++;
      if (n !== 35 || bus.out !== ex[i]) begin
        errs++;
        $display("FAIL b2b%0d: cycles=%0d out=%h want 35 %h",
                 i, n, bus.out, ex[i]);
      end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.func      = INT_ADD;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_divide();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_kill();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/intdiv_seq.md
Name: intdiv_seq

Overview:
- Multi-cycle radix-2 restoring divider for the bexkat1 execute stage.
- Takes the same intfunc_t divide/modulo codes as the combinational integer unit and drives the same result mux.
- Replaces the single-cycle `/` and `%` paths so the core can close timing.
- Valid/ready handshake on both sides; the pipeline stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand and result width in bits (even, >= 8).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous and active-low.
- kill_i  in  1  pipeline flush; abandons any operation in flight.
- in_valid  in  1  request present.
- in_ready  out  1  divider can accept a request.
- func  in  intfunc_t  operation: INT_DIV, INT_MOD, INT_DIVU or INT_MODU.
- dividend  in  WIDTH  numerator, two's complement when func is signed.
- divisor  in  WIDTH  denominator.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  quotient or remainder.
- dbz  out  1  divide-by-zero flag, qualified by out_valid.

Behaviour:
- Reset (rst_i low at a clock edge):
  - state=IDLE, count=0.
  - out=0, out_valid=0, dbz=0, in_ready=1.
  - Reset wins over every other input, including mid-operation.
- State machine: IDLE -> CALC -> FIX -> DONE -> IDLE.
- in_ready = (state==IDLE). An accept is in_valid & in_ready at an edge.
- On accept, latch:
  - func;
  - the sign of the dividend, and the XOR of the operand signs (signed ops only);
  - the absolute values of both operands;
  - count = WIDTH.
- Next state after accept:
  - divisor==0: go to DONE; out = all-ones for DIV/DIVU, out = dividend for MOD/MODU; dbz=1.
  - func not one of the four divide codes: go to DONE; out=0, dbz=0.
  - otherwise: go to CALC.
- CALC, one quotient bit per cycle:
  - shift {rem,quo} left by one;
  - trial = rem - divisor;
  - if trial is non-negative, rem = trial and the quotient LSB = 1;
  - decrement count; at count==1 go to FIX.
  - rem is held in WIDTH+1 bits.
- FIX:
  - Signed ops: quotient is negated if the operand signs differ. Remainder is negated if the dividend was negative. This gives truncation toward zero, with the remainder taking the dividend's sign.
  - out is selected by func; dbz=0; go to DONE.
- Overflow case: signed MIN / -1 gives quotient MIN and remainder 0. This falls out of the datapath with no special case.
- DONE:
  - out_valid=1; out and dbz are held stable.
  - On out_ready, go to IDLE. out_valid drops; out keeps its value.
- Latency from the accept edge to out_valid high:
  - normal divide: WIDTH+2 edges;
  - divide-by-zero or invalid func: 1 edge.
- Throughput: one operation per WIDTH+3 cycles when out_ready is held high. There is no overlap between operations.
- kill_i high at an edge, in any state:
  - go to IDLE; out_valid=0 that edge.
  - A request presented on the same edge is not accepted.
  - kill_i takes priority over accept and over out_ready.
- Backpressure: DONE is held indefinitely while out_ready=0.
- The input operands are not required to stay stable after accept.

Decomposition:
- In the bexkat1Def package:
  - divstate_t enum {IDLE, CALC, FIX, DONE};
  - an is_divfunc helper on intfunc_t;
  - a function that reports whether a func is signed.
- One sub-module, intdiv_step: combinational shift/subtract of one bit. Inputs are rem, quo and divisor; outputs are the next rem and quo.
- The FSM, counter and sign fix-up stay in intdiv_seq.

Test Plan:
- DIVU 100/7 -> out=14 after exactly 34 edges; MODU 100/7 -> out=2; dbz=0.
- DIV -7/2 -> 0xFFFFFFFD (-3); MOD -7/2 -> 0xFFFFFFFF (-1); MOD 7/-2 -> 1.
- DIVU 0x1234/0 -> out=0xFFFFFFFF, dbz=1, out_valid 1 edge after accept. MOD -5/0 -> out=0xFFFFFFFB.
- DIV 0x80000000/0xFFFFFFFF -> out=0x80000000; MOD with the same operands -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Require out stable, in_ready=0 throughout. After out_ready=1 for one edge, in_ready=1 on the next cycle.
- Abort paths:
  - rst_i=0 at count==16 -> next cycle in_ready=1, out_valid=0, out=0.
  - kill_i=1 mid-CALC with in_valid=1 -> request not accepted; IDLE next cycle.
